fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the asynchronous FIFO among NUM_REQ requesters in the write clock domain. It grants one requester at a time for a bounded burst, drives the FIFO's `w_en`/`data_in` directly, and never issues a write while the FIFO reports `full`. It sits between the write-side producers and the FIFO write port. Burst length shortens to one word while the FIFO reports `half_full`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, FIFO word width; must match the FIFO
- MAX_BURST, 4, maximum words per grant (1..15)

Ports:
- wclk  in  1  write-domain clock, rising edge
- wrst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request; bit i = requester i
- req_data  in  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH]
- full  in  1  FIFO full flag (write domain)
- half_full  in  1  FIFO half-full flag (write domain)
- gnt  out  NUM_REQ  one-hot grant, registered; all-zero when idle
- gnt_id  out  $clog2(NUM_REQ)  index of current/last owner, registered
- w_en  out  1  FIFO write enable (combinational from registered state)
- data_in  out  DATA_WIDTH  FIFO write data; granted requester's word
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Registers: state, gnt, gnt_id (owner), last (round-robin pointer), burst_cnt (4 bits), burst_lim (4 bits).
- IDLE: if any req bit set and full=0, select the first set req bit scanning last+1, last+2, ... modulo NUM_REQ. Load gnt=one-hot(winner), gnt_id=winner, last=winner, burst_cnt=0, burst_lim = half_full ? 1 : MAX_BURST. Move to GRANT. Otherwise stay in IDLE. While full=1, no grant is issued.
- GRANT, accept = req[gnt_id] & ~full. A word is written in exactly the cycles where accept=1.
- w_en = busy & accept; data_in = req_data slice gnt_id (data_in outside w_en is don't-care, but stays the gnt_id slice).
- On accept: burst_cnt += 1. Release (to IDLE, gnt=0) when burst_cnt+1 == burst_lim.
- If req[gnt_id]=0 in GRANT: release immediately without writing.
- If full=1 with req[gnt_id]=1: hold the grant, no write, burst_cnt unchanged. There is no timeout.
- Requesters must hold req and data stable until the cycle their word is accepted (gnt & w_en visible). Dropping req ends the burst.
- half_full is sampled only at grant time. A change mid-burst does not alter burst_lim.

## Timing
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, w_en=0, last=NUM_REQ-1 (requester 0 wins first), burst_cnt=0, burst_lim=0.
- Reset is asynchronous. The assertion clears gnt/busy at once, and w_en falls in the same instant. In-flight bursts are abandoned and no partial write is issued after reset.
- Latency: req rises before edge N in IDLE → gnt/busy high after edge N → first w_en in cycle N (after edge N) if full=0.
- Back-to-back burst: after release there is one IDLE cycle before the next grant. Peak throughput is MAX_BURST/(MAX_BURST+1).
- w_en depends combinationally on full. The FIFO's registered full must therefore be valid in the same cycle, so no write occurs into a full FIFO.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.

## Test plan
- Reset/first grant: hold wrst, req=4'b1111, then deassert → gnt=4'b0001 one cycle after the first edge, 4 writes of requester 0 data, then IDLE for 1 cycle, then gnt=4'b0010.
- Round-robin: req=4'b1010 continuous, full=0 → grant order 1,3,1,3; each burst exactly 4 w_en pulses with the correct data_in.
- Full stall: during a grant to requester 2 after 2 words, force full=1 for 5 cycles → w_en=0, gnt held. Release full → exactly 2 more writes, then release.
- Half-full throttle: half_full=1 at grant, req=4'b0001 held → exactly 1 w_en per grant, with alternating GRANT/IDLE cycles.
- Early drop: requester 3 drops req after 1 accepted word → gnt clears next edge, total writes = 1; the scoreboard matches FIFO contents.
- Reset mid-burst: assert wrst asynchronously while w_en=1 → gnt=0, w_en=0 immediately. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ write-domain requesters.
// Grants a bounded burst per owner, shortened to one word while the FIFO is half full.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                            full,
    input  logic                            half_full,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in,
    output logic                            busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]     gnt_id_q, gnt_id_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic [3:0]         burst_lim_q, burst_lim_d;

    logic               found;
    logic [IdW-1:0]     winner;
    logic [IdW-1:0]     scan_idx;
    logic               accept;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            last_q      <= IdW'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            burst_lim_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            burst_lim_q <= burst_lim_d;
        end
    end

    // First requesting index after the last owner, wrapping modulo NUM_REQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = IdW'((32'(last_q) + k) % NUM_REQ);
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign accept = req[gnt_id_q] & ~full;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        burst_lim_d = burst_lim_q;
        unique case (state_q)
            StIdle: begin
                if (found && !full) begin
                    state_d     = StGrant;
                    gnt_d       = NUM_REQ'(1) << winner;
                    gnt_id_d    = winner;
                    last_d      = winner;
                    burst_cnt_d = '0;
                    burst_lim_d = half_full ? 4'd1 : 4'(MAX_BURST);
                end
            end
            StGrant: begin
                if (!req[gnt_id_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end else if (!full) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q + 4'd1 == burst_lim_q) begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
                // full with an active request: hold grant and count, no timeout
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == StGrant);
        w_en    = busy & accept;
        gnt     = gnt_q;
        gnt_id  = gnt_id_q;
        data_in = req_data[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
    end

endmodule
